spinn_pkt_arbiter: RTL and testbench
====================================

Name: spinn_pkt_arbiter

Overview:
- Shares a single SpiNNaker packet interface between NUM_SRC independent packet producers, such as per-sensor AER-to-packet mappers.
- Arbitrates round-robin at packet granularity and drives the shared interface from one registered output stage.
- Owns the "SpiNNaker not responding" dump policy: producers never stall indefinitely, and dropped packets are counted per source.

Parameters:
- NUM_SRC, 3, number of requesting sources; legal range 2..4.
- PKT_WIDTH, 72, packet width (SpiNNaker key/payload word).
- DUMP_TIMEOUT, 128, consecutive cycles with opkt_rdy low before entering dump; legal range 1..255.
- CNT_WIDTH, 16, width of each per-source drop counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_data  in  NUM_SRC*PKT_WIDTH  source packets; source i occupies bits [i*PKT_WIDTH +: PKT_WIDTH]
- src_vld  in  NUM_SRC  per-source valid
- src_rdy  out  NUM_SRC  per-source ready (combinational)
- src_en  in  NUM_SRC  per-source enable mask (static configuration)
- opkt_data  out  PKT_WIDTH  shared packet output (registered)
- opkt_vld  out  1  shared packet valid (registered)
- opkt_rdy  in  1  shared packet ready from spinn_driver
- opkt_src  out  2  index of the source of the current opkt_data (registered)
- dump_mode  out  1  high while packets are being discarded (registered)
- drop_cnt_clr  in  1  synchronous clear of all drop counters
- drop_cnt  out  NUM_SRC*CNT_WIDTH  per-source saturating drop counts

Behaviour:
- Reset (rst_n low, asynchronous):
  - opkt_vld=0, opkt_data=0, opkt_src=0, dump_mode=0.
  - Round-robin pointer=0; timer=DUMP_TIMEOUT; all drop_cnt=0; state=FWD.
- Handshakes:
  - A transfer occurs on vld&rdy.
  - src_vld must not depend on src_rdy.
  - A source holds its data stable while vld is high and rdy is low.
- Output stage load condition: load = ~opkt_vld | opkt_rdy.
- Throughput and latency: one packet per cycle sustained; one cycle from source handshake to opkt_vld.
- State FWD:
  - Candidates are sources with src_vld & src_en.
  - Winner is the first candidate found scanning from the pointer upward, modulo NUM_SRC.
  - If load is true and a winner exists:
    - src_rdy[winner]=1.
    - Next cycle: opkt_data = that source's packet, opkt_src = winner, opkt_vld=1.
    - pointer <= (winner+1) mod NUM_SRC.
  - If load is true and there is no candidate, opkt_vld <= 0.
  - Losing enabled sources see src_rdy=0.
- Disabled sources (src_en[i]=0):
  - src_rdy[i]=1 in every state; packets are flushed.
  - Flushed packets are not forwarded, not counted and never granted.
  - The pointer skips disabled sources.
- Timer:
  - Reloads to DUMP_TIMEOUT on any cycle with opkt_rdy=1.
  - Otherwise decrements each cycle and holds at 0.
  - The timer runs regardless of opkt_vld.
- FWD->DUMP: taken when the timer is 0 and opkt_rdy=0; dump_mode <= 1 on that edge.
- State DUMP:
  - All src_rdy=1; every accepted enabled packet is discarded.
  - For each accepted packet, drop_cnt[i] increments and saturates at all ones.
  - The output stage keeps its held packet: opkt_vld and opkt_data stay frozen until opkt_rdy.
- DUMP->FWD: taken on the first cycle opkt_rdy=1.
  - That cycle still behaves as DUMP for the sources (discard and count).
  - The held output packet transfers normally.
  - dump_mode <= 0 on the same edge; the timer reloads.
- Simultaneous drop_cnt_clr and increment: clear wins; the counter becomes 0 and that increment is lost.
- Pointer: does not advance in DUMP or on flushes.
- Reset mid-packet: the output packet is lost and no partial state is retained; sources must re-present.
- opkt_src width: fixed at 2; for NUM_SRC<4 the unused codes are never driven.

Test Plan:
- Fair arbitration:
  - Stimulus: NUM_SRC=3, all enabled, all src_vld=1 continuously, opkt_rdy=1, packets tagged 0xA0/0xB0/0xC0.
  - Required: opkt_src sequence 0,1,2,0,1,2; one packet per cycle; first opkt_vld one cycle after reset release plus the first grant; dump_mode=0 throughout.
- Backpressure hold:
  - Stimulus: opkt_rdy=0 for 10 cycles with opkt_vld=1.
  - Required: opkt_data/opkt_src stable; all src_rdy=0; no drop_cnt change; after opkt_rdy=1 the next grant continues round-robin order.
- Dump entry and exit:
  - Stimulus: DUMP_TIMEOUT=128, opkt_rdy=0 from cycle 0, source 1 streaming continuously.
  - Required: dump_mode rises exactly 129 cycles after opkt_rdy falls; src_rdy=0b111; drop_cnt[1] increments every cycle.
  - Then: opkt_rdy=1 for one cycle makes dump_mode=0 next cycle; the held packet is delivered exactly once.
- Disable mask:
  - Stimulus: src_en=0b101, all valid.
  - Required: only sources 0 and 2 appear alternately on opkt_src; src_rdy[1]=1 always; drop_cnt[1] stays 0.
- Counter saturation and clear:
  - Stimulus: CNT_WIDTH=4, 20 drops on source 0.
  - Required: drop_cnt[0]=15 and holds.
  - Then: drop_cnt_clr together with a drop gives 0 next cycle; a drop the following cycle gives 1.
- Async reset mid-stream:
  - Stimulus: assert rst_n low between clock edges while opkt_vld=1 in DUMP.
  - Required: outputs clear immediately; after release, the first grant goes to source 0 and the timer restarts at 128.

Source files
------------

// File: rtl/spinn_pkt_arbiter.sv
// Round-robin arbiter sharing one registered SpiNNaker packet output between
// NUM_SRC producers, with a timeout-driven dump mode and per-source drop counters.
module spinn_pkt_arbiter #(
    parameter int NUM_SRC      = 3,
    parameter int PKT_WIDTH    = 72,
    parameter int DUMP_TIMEOUT = 128,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC*PKT_WIDTH-1:0]   src_data,
    input  logic [NUM_SRC-1:0]             src_vld,
    output logic [NUM_SRC-1:0]             src_rdy,
    input  logic [NUM_SRC-1:0]             src_en,
    output logic [PKT_WIDTH-1:0]           opkt_data,
    output logic                           opkt_vld,
    input  logic                           opkt_rdy,
    output logic [1:0]                     opkt_src,
    output logic                           dump_mode,
    input  logic                           drop_cnt_clr,
    output logic [NUM_SRC*CNT_WIDTH-1:0]   drop_cnt
);

    // Valid/ready: a transfer happens on any cycle where vld & rdy are both high;
    // vld never depends on rdy and data stays stable while vld & ~rdy.
    typedef enum logic {FWD = 1'b0, DUMP = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [1:0]             ptr;
    logic [7:0]             timer;
    logic                   load;
    logic                   grant;
    logic                   win_vld;
    logic [1:0]             win_idx;
    logic [NUM_SRC-1:0]     cand;
    logic [CNT_WIDTH-1:0]   cnt [NUM_SRC];

    // The FSM state is observable directly: dump_mode is the state register.
    assign dump_mode = (state == DUMP);
    assign load      = ~opkt_vld | opkt_rdy;
    assign cand      = src_vld & src_en;
    assign grant     = (state == FWD) && load && win_vld;

    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = 2'd0;
        idx     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            if (!win_vld && cand[idx]) begin
                win_vld = 1'b1;
                win_idx = 2'(idx);
            end
        end
    end

    // Disabled sources are always drained; in DUMP every source is drained.
    always_comb begin
        src_rdy = ~src_en;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (state == DUMP)
                src_rdy[i] = 1'b1;
            else if (grant && (int'(win_idx) == i))
                src_rdy[i] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FWD:     if (timer == 8'd0 && !opkt_rdy) state_nxt = DUMP;
            DUMP:    if (opkt_rdy) state_nxt = FWD;
            default: state_nxt = FWD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FWD;
            ptr       <= 2'd0;
            timer     <= 8'(DUMP_TIMEOUT);
            opkt_vld  <= 1'b0;
            opkt_data <= '0;
            opkt_src  <= 2'd0;
        end else begin
            state <= state_nxt;
            if (opkt_rdy)
                timer <= 8'(DUMP_TIMEOUT);
            else if (timer != 8'd0)
                timer <= timer - 8'd1;

            if (state == FWD && load) begin
                if (win_vld) begin
                    opkt_vld  <= 1'b1;
                    opkt_data <= src_data[int'(win_idx)*PKT_WIDTH +: PKT_WIDTH];
                    opkt_src  <= win_idx;
                    ptr       <= 2'((int'(win_idx) + 1) % NUM_SRC);
                end else begin
                    opkt_vld <= 1'b0;
                end
            end else if (state == DUMP && opkt_rdy) begin
                // The frozen packet leaves on this edge; nothing new is loaded in DUMP.
                opkt_vld <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt[g] <= '0;
            else if (drop_cnt_clr)
                cnt[g] <= '0;
            else if (state == DUMP && cand[g] && !(&cnt[g]))
                cnt[g] <= cnt[g] + 1'b1;
        end
        assign drop_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
    end

endmodule

// File: tb/tb_spinn_pkt_arbiter.sv
// Directed bench for spinn_pkt_arbiter: arbitration order, backpressure, masking,
// dump entry/exit, counter saturation/clear and asynchronous reset.
module tb_spinn_pkt_arbiter;

    localparam int NS = 3;
    localparam int PW = 72;
    localparam int CW = 4;
    localparam int TO = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS*PW-1:0]  src_data;
    logic [NS-1:0]     src_vld;
    logic [NS-1:0]     src_rdy;
    logic [NS-1:0]     src_en;
    logic [PW-1:0]     opkt_data;
    logic              opkt_vld;
    logic              opkt_rdy;
    logic [1:0]        opkt_src;
    logic              dump_mode;
    logic              drop_cnt_clr;
    logic [NS*CW-1:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    spinn_pkt_arbiter #(.NUM_SRC(NS), .PKT_WIDTH(PW), .DUMP_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_vld(src_vld),
        .src_rdy(src_rdy), .src_en(src_en), .opkt_data(opkt_data), .opkt_vld(opkt_vld),
        .opkt_rdy(opkt_rdy), .opkt_src(opkt_src), .dump_mode(dump_mode),
        .drop_cnt_clr(drop_cnt_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pkt(input int i);
        logic [7:0] tag;
        tag = 8'hA0 + 8'(i * 16);
        return (72'(i + 1) << 64) | 72'(tag);
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int i);
        return drop_cnt[i*CW +: CW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; src_en = 3'b111; src_vld = 3'b000; opkt_rdy = 1'b1; drop_cnt_clr = 1'b0;
        src_data = {pkt(2), pkt(1), pkt(0)};
        step(); step();
        checks++;
        if ({opkt_vld, opkt_src, dump_mode} !== 4'b0000 || opkt_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: vld=%0b src=%0d dump=%0b data=%h, required 0/0/0/0",
                     opkt_vld, opkt_src, dump_mode, opkt_data);
        end
        checks++;
        if (drop_cnt !== '0 || src_rdy !== 3'b000) begin
            errors++;
            $display("FAIL reset_cnt_rdy: drop_cnt=%h src_rdy=%b, required 0 / 000", drop_cnt, src_rdy);
        end
    endtask

    task automatic test_fair();
        src_vld = 3'b111;
        rst_n = 1'b1;
        #1;
        checks++;
        if (src_rdy !== 3'b001) begin
            errors++;
            $display("FAIL fair_first_rdy: src_rdy=%b, required 001", src_rdy);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (opkt_vld !== 1'b1 || opkt_src !== 2'(k % 3) || opkt_data !== pkt(k % 3) || dump_mode !== 1'b0) begin
                errors++;
                $display("FAIL fair_seq[%0d]: vld=%0b src=%0d data=%h dump=%0b, required 1/%0d/%h/0",
                         k, opkt_vld, opkt_src, opkt_data, dump_mode, k % 3, pkt(k % 3));
            end
        end
    endtask

    task automatic test_backpressure();
        opkt_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (opkt_src !== 2'd2 || opkt_data !== pkt(2) || opkt_vld !== 1'b1 ||
                src_rdy !== 3'b000 || drop_cnt !== '0 || dump_mode !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: src=%0d data=%h vld=%0b rdy=%b cnt=%h dump=%0b, required 2/%h/1/000/0/0",
                         k, opkt_src, opkt_data, opkt_vld, src_rdy, drop_cnt, dump_mode, pkt(2));
            end
        end
        opkt_rdy = 1'b1;
        #1;
        checks++;
        if (src_rdy !== 3'b001) begin
            errors++;
            $display("FAIL bp_release_rdy: src_rdy=%b, required 001", src_rdy);
        end
        step();
        checks++;
        if (opkt_src !== 2'd0 || opkt_vld !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume: src=%0d vld=%0b, required 0/1", opkt_src, opkt_vld);
        end
    endtask

    task automatic test_disable();
        src_en = 3'b101;
        #1;
        checks++;
        if (src_rdy !== 3'b110) begin
            errors++;
            $display("FAIL dis_first_rdy: src_rdy=%b, required 110", src_rdy);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (opkt_src !== ((k % 2 == 0) ? 2'd2 : 2'd0) || src_rdy[1] !== 1'b1 || cnt_of(1) !== '0) begin
                errors++;
                $display("FAIL dis_seq[%0d]: src=%0d rdy1=%0b cnt1=%0d, required %0d/1/0",
                         k, opkt_src, src_rdy[1], cnt_of(1), (k % 2 == 0) ? 2 : 0);
            end
        end
    endtask

    task automatic test_dump();
        int n;
        src_en = 3'b111; src_vld = 3'b010; opkt_rdy = 1'b0;
        n = 0;
        while (dump_mode !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n !== 129) begin
            errors++;
            $display("FAIL dump_entry_cycles: got %0d, required 129", n);
        end
        checks++;
        if (src_rdy !== 3'b111 || cnt_of(1) !== 4'd0 || opkt_vld !== 1'b1 ||
            opkt_src !== 2'd0 || opkt_data !== pkt(0)) begin
            errors++;
            $display("FAIL dump_enter_state: rdy=%b cnt1=%0d vld=%0b src=%0d data=%h, required 111/0/1/0/%h",
                     src_rdy, cnt_of(1), opkt_vld, opkt_src, opkt_data, pkt(0));
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (cnt_of(1) !== 4'(k) || opkt_data !== pkt(0) || opkt_vld !== 1'b1) begin
                errors++;
                $display("FAIL dump_count[%0d]: cnt1=%0d data=%h vld=%0b, required %0d/%h/1",
                         k, cnt_of(1), opkt_data, opkt_vld, k, pkt(0));
            end
        end
        opkt_rdy = 1'b1;
        step();
        checks++;
        if (dump_mode !== 1'b0 || opkt_vld !== 1'b0 || cnt_of(1) !== 4'd4) begin
            errors++;
            $display("FAIL dump_exit: dump=%0b vld=%0b cnt1=%0d, required 0/0/4", dump_mode, opkt_vld, cnt_of(1));
        end
        checks++;
        if (src_rdy !== 3'b010) begin
            errors++;
            $display("FAIL dump_exit_rdy: src_rdy=%b, required 010", src_rdy);
        end
        step();
        checks++;
        if (opkt_src !== 2'd1 || opkt_vld !== 1'b1 || opkt_data !== pkt(1)) begin
            errors++;
            $display("FAIL dump_resume: src=%0d vld=%0b data=%h, required 1/1/%h", opkt_src, opkt_vld, opkt_data, pkt(1));
        end
    endtask

    task automatic test_saturation();
        int n;
        src_vld = 3'b001; opkt_rdy = 1'b0;
        n = 0;
        while (dump_mode !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (dump_mode !== 1'b1) begin
            errors++;
            $display("FAIL sat_dump_entry: dump_mode=%0b after %0d cycles, required 1", dump_mode, n);
        end
        for (int k = 0; k < 20; k++) step();
        checks++;
        if (cnt_of(0) !== 4'd15 || cnt_of(1) !== 4'd4) begin
            errors++;
            $display("FAIL sat_value: cnt0=%0d cnt1=%0d, required 15/4", cnt_of(0), cnt_of(1));
        end
        step();
        checks++;
        if (cnt_of(0) !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: cnt0=%0d, required 15", cnt_of(0));
        end
        drop_cnt_clr = 1'b1;
        step();
        checks++;
        if (cnt_of(0) !== 4'd0 || cnt_of(1) !== 4'd0) begin
            errors++;
            $display("FAIL clr_wins: cnt0=%0d cnt1=%0d, required 0/0", cnt_of(0), cnt_of(1));
        end
        drop_cnt_clr = 1'b0;
        step();
        checks++;
        if (cnt_of(0) !== 4'd1) begin
            errors++;
            $display("FAIL clr_then_drop: cnt0=%0d, required 1", cnt_of(0));
        end
    endtask

    task automatic test_async_reset();
        int n;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (opkt_vld !== 1'b0 || dump_mode !== 1'b0 || opkt_src !== 2'd0 ||
            opkt_data !== '0 || drop_cnt !== '0) begin
            errors++;
            $display("FAIL areset_clear: vld=%0b dump=%0b src=%0d data=%h cnt=%h, required all 0",
                     opkt_vld, dump_mode, opkt_src, opkt_data, drop_cnt);
        end
        src_vld = 3'b111; opkt_rdy = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
        checks++;
        if (src_rdy !== 3'b001) begin
            errors++;
            $display("FAIL areset_first_rdy: src_rdy=%b, required 001", src_rdy);
        end
        step();
        checks++;
        if (opkt_vld !== 1'b1 || opkt_src !== 2'd0 || opkt_data !== pkt(0)) begin
            errors++;
            $display("FAIL areset_first_grant: vld=%0b src=%0d data=%h, required 1/0/%h",
                     opkt_vld, opkt_src, opkt_data, pkt(0));
        end
        n = 1;
        while (dump_mode !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n !== 129) begin
            errors++;
            $display("FAIL areset_timer: dump after %0d cycles, required 129", n);
        end
    endtask

    initial begin
        test_reset();
        test_fair();
        test_backpressure();
        test_disable();
        test_dump();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
